// File: rtl/evt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : evt_pkg
// Purpose  : Shared defaults and types for the match event logger.
// Revision : 1.0 - initial release
// ============================================================================
package evt_pkg;

  localparam int unsigned c_DEPTH = 4;
  localparam int unsigned c_TS_W  = 8;
  localparam int unsigned c_CNT_W = 8;

  typedef logic [c_TS_W-1:0] ts_t;

endpackage
`default_nettype wire

// File: rtl/match_event_logger_if.sv
`default_nettype none
// ============================================================================
// Module   : match_event_logger_if
// Purpose  : Valid/ready read port carrying queued event timestamps.
// Revision : 1.0 - initial release
// ============================================================================
interface match_event_logger_if
  import evt_pkg::*;
#(
  parameter int unsigned TS_W = c_TS_W
) ();

  logic            rd_valid;
  logic            rd_ready;
  logic [TS_W-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);

endinterface
`default_nettype wire

// File: rtl/evt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : evt_fifo
// Purpose  : Synchronous FIFO with wrap-bit pointers, push/pop/clr.
// Revision : 1.0 - initial release
// ============================================================================
module evt_fifo
  import evt_pkg::*;
#(
  parameter int unsigned DEPTH = c_DEPTH,
  parameter int unsigned WIDTH = c_TS_W
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             clr,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [WIDTH-1:0] wr_data,
  output logic      [WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned c_AW = $clog2(DEPTH);

  logic [c_AW:0]      r_wr_ptr;
  logic [c_AW:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_push_ok;
  logic               w_pop_ok;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                 (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);

  assign rd_data = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_push_ok && !clr) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/match_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : match_event_logger
// Purpose  : Rising-edge match events, timestamped into a FIFO and counted.
// Revision : 1.0 - initial release
// ============================================================================
module match_event_logger
  import evt_pkg::*;
#(
  parameter int unsigned DEPTH = c_DEPTH,
  parameter int unsigned TS_W  = c_TS_W,
  parameter int unsigned CNT_W = c_CNT_W
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             ena,
  input  wire logic             match_in,
  input  wire logic             clr,
  match_event_logger_if.master  rd,
  output logic      [CNT_W-1:0] evt_count,
  output logic                  fifo_full,
  output logic                  overflow
);

  logic             r_match_d;
  logic [TS_W-1:0]  r_ts;
  logic [CNT_W-1:0] r_evt_count;
  logic             r_overflow;
  logic             w_event;
  logic             w_empty;
  logic             w_full;
  logic [TS_W-1:0]  w_head;

  assign w_event = ena & match_in & ~r_match_d;

  evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TS_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .push    (w_event & ~clr),
    .pop     (rd.rd_ready & ~clr),
    .wr_data (r_ts),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match_d   <= 1'b0;
      r_ts        <= '0;
      r_evt_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      // Edge history keeps tracking through clr so a held level stays one event.
      r_match_d <= match_in;
      if (clr) begin
        r_ts        <= '0;
        r_evt_count <= '0;
        r_overflow  <= 1'b0;
      end else begin
        if (ena) r_ts <= r_ts + TS_W'(1);
        if (w_event && !(&r_evt_count)) r_evt_count <= r_evt_count + CNT_W'(1);
        if (w_event && w_full && !rd.rd_ready) r_overflow <= 1'b1;
      end
    end
  end

  assign rd.rd_valid = ~w_empty;
  assign rd.rd_data  = w_head;
  assign evt_count   = r_evt_count;
  assign fifo_full   = w_full;
  assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: doc/match_event_logger.md
# match_event_logger

Downstream consumer of the adaptive pattern detector's `uo_out[0]` match flag. It converts each held match pulse into a single event and counts events with saturation. Each event is stamped with a free-running cycle timestamp and queued in a small FIFO, which a host or test harness drains through a valid/ready read port. Overflow is reported through a sticky flag, never silently.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries, power of two, ≥2
- `TS_W`, 8: timestamp width, bits
- `CNT_W`, 8: event counter width, bits

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `ena` in 1: global enable; when low, the timestamp freezes and no events are detected
- `match_in` in 1: detector match level; high for 1–4 consecutive cycles per detection
- `clr` in 1: synchronous clear of FIFO, counter, timestamp and overflow
- `rd_ready` in 1: consumer accepts the head entry this cycle
- `rd_valid` out 1: FIFO non-empty
- `rd_data` out TS_W: timestamp of the oldest queued event
- `evt_count` out CNT_W: total events since reset/clr, saturating
- `fifo_full` out 1: FIFO holds DEPTH entries
- `overflow` out 1: sticky; set when an event is dropped because the FIFO is full

## Operation
- `match_d` register captures `match_in` every cycle, regardless of `ena`.
- Event = `ena & match_in & ~match_d`, i.e. a rising edge. A held level yields exactly one event.
  - A rising edge during `ena`=0 is lost; it is not recovered later.
- Timestamp `ts`: increments by 1 each cycle while `ena`=1, wrapping at 2^TS_W−1 → 0.
- On an event:
  - The current `ts` value (pre-increment) is pushed to the FIFO.
  - `evt_count` += 1, holding at 2^CNT_W−1.
- Pop on `rd_valid & rd_ready`. `rd_ready` while empty has no effect.
- Push while full:
  - With a simultaneous pop: the pop frees a slot and the push succeeds. No overflow.
  - Without a pop: the event is dropped, `overflow` is set, and `evt_count` still increments.
- Simultaneous push and pop while empty: the push succeeds, the pop is ignored, and `rd_valid` rises next cycle.
- `clr`:
  - Takes priority over push and pop in the same cycle.
  - Next cycle: FIFO empty, `ts`=0, `evt_count`=0, `overflow`=0.
  - `match_d` still updates, so a level held across `clr` produces no event.
- Pointers are log2(DEPTH)+1 bits with a wrap bit. Full = indices equal with wrap bits differing. Empty = pointers equal.

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `evt_count`=0, `fifo_full`=0, `overflow`=0. Internally `ts`=0, `match_d`=0, pointers 0.
- Latency: an event sampled at edge t is visible at the outputs after edge t:
  - `rd_valid`=1
  - `evt_count` updated
  - `rd_data` equals the entry's timestamp, provided the FIFO was previously empty
- `rd_data` is a registered-storage read of the head entry. It changes only after a pop or after the first push into an empty FIFO.
- Throughput: one push and one pop per cycle.
- Minimum spacing of detectable events: 2 cycles (a low sample is required between them).
- Asynchronous reset mid-operation clears everything immediately. The first event can occur at the first edge after deassertion with `match_in`=1.

## Structure
- Shared package `evt_pkg`: `DEPTH`, `TS_W`, `CNT_W` defaults; the `ts_t` typedef (logic [TS_W-1:0]).
- Sub-module `evt_fifo`: synchronous FIFO with wrap-bit pointers and push/pop/clr, exposing full/empty.
- Edge detection, timestamp, counter and overflow logic live in the top level.

## Test plan
- Reset, then `match_in` high for 4 cycles starting at `ts`=5 → one event; `rd_data`=5, `evt_count`=1, `rd_valid`=1; a pop empties the FIFO.
- 5 events with no reads, `DEPTH`=4 → `fifo_full`=1, `overflow`=1, `evt_count`=5; reads return the first four timestamps in order.
- FIFO full, event coinciding with `rd_ready`=1 → `overflow` stays 0; FIFO stays full; the new timestamp appears last.
- `ts` run to 255, event at `ts`=255, next event at `ts`=1 → reads return 255 then 1.
- `clr` in the same cycle as an event with 2 entries queued → next cycle empty, `evt_count`=0, `ts`=0, `overflow`=0; no event while the level persists.
- `ena`=0 during a `match_in` rise, `ena`=1 while still high → no event; `ts` frozen while `ena`=0; 300 events → `evt_count` saturates at 255.
